// File: rtl/ppu_vram_resp.sv
// PPU VRAM responder: decodes CHR / nametable / palette and returns data two cycles after acceptance.
// Define PPU_VRAM_CHR_RAM_EN to forward CPU writes at $0000-$1FFF to cartridge CHR-RAM.
module ppu_vram_resp #(
    parameter int NT_AW = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mirror_v,
    input  logic        fetch_req,
    input  logic [13:0] fetch_addr,
    output logic        fetch_valid,
    output logic [7:0]  fetch_data,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [13:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_done,
    output logic [7:0]  cpu_rdata,
    output logic        chr_rd,
    output logic        chr_we,
    output logic [12:0] chr_addr,
    output logic [7:0]  chr_wdata,
    input  logic [7:0]  chr_data
);

    typedef enum logic [1:0] {TGT_CHR, TGT_NT, TGT_PAL} tgt_t;

    logic             w_cpu_acc;
    logic             w_acc;
    logic             w_we;
    logic [13:0]      w_addr;
    tgt_t             w_tgt;

    logic             r_cpu_busy;
    logic [7:0]       r_rd_buf;
    logic             r_s1_vld;
    logic             r_s1_cpu;
    logic             r_s1_we;
    tgt_t             r_s1_tgt;
    logic [11:0]      r_s1_addr;
    logic [7:0]       r_s1_wdata;

    logic [7:0]       r_nt_mem [2**NT_AW];
    logic [5:0]       r_pal [32];

    logic [NT_AW-1:0] w_nt_addr;
    logic [4:0]       w_pal_idx;
    logic [7:0]       w_nt_rd;
    logic [7:0]       w_pal_rd;
    logic [7:0]       w_src;

    always_comb begin
        w_cpu_acc = cpu_req && !fetch_req && !r_cpu_busy;
        w_acc     = fetch_req || w_cpu_acc;
        w_we      = w_cpu_acc && cpu_we;
        w_addr    = fetch_req ? fetch_addr : cpu_addr;
        if (!w_addr[13])
            w_tgt = TGT_CHR;
        else if (w_addr[13:8] == 6'h3F)
            w_tgt = TGT_PAL;
        else
            w_tgt = TGT_NT;
    end

    // Bits [11:0] of $3Fxx equal those of $2Fxx, so w_nt_rd already holds the
    // byte that a palette CPU read must load into the read buffer.
    always_comb begin
        w_nt_addr = NT_AW'({mirror_v ? r_s1_addr[10] : r_s1_addr[11], r_s1_addr[9:0]});
        w_pal_idx = {r_s1_addr[4] & (r_s1_addr[1:0] != 2'b00), r_s1_addr[3:0]};
        w_nt_rd   = r_nt_mem[w_nt_addr];
        w_pal_rd  = {2'b00, r_pal[w_pal_idx]};
        case (r_s1_tgt)
            TGT_CHR: w_src = chr_data;
            TGT_PAL: w_src = w_pal_rd;
            default: w_src = w_nt_rd;
        endcase
    end

    // Nametable contents survive reset; writes of an access dropped by reset are suppressed.
    always_ff @(posedge clk) begin
        if (!rst && r_s1_vld && r_s1_cpu && r_s1_we && r_s1_tgt == TGT_NT)
            r_nt_mem[w_nt_addr] <= r_s1_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld    <= 1'b0;
            r_s1_cpu    <= 1'b0;
            r_s1_we     <= 1'b0;
            r_s1_tgt    <= TGT_CHR;
            r_s1_addr   <= '0;
            r_s1_wdata  <= '0;
            r_cpu_busy  <= 1'b0;
            r_rd_buf    <= '0;
            chr_rd      <= 1'b0;
            chr_addr    <= '0;
            fetch_valid <= 1'b0;
            fetch_data  <= '0;
            cpu_done    <= 1'b0;
            cpu_rdata   <= '0;
            for (int unsigned i = 0; i < 32; i++)
                r_pal[i] <= '0;
        end else begin
            r_s1_vld   <= w_acc;
            r_s1_cpu   <= w_cpu_acc;
            r_s1_we    <= w_we;
            r_s1_tgt   <= w_tgt;
            r_s1_addr  <= w_addr[11:0];
            r_s1_wdata <= cpu_wdata;

            if (w_cpu_acc)
                r_cpu_busy <= 1'b1;
            else if (cpu_done)
                r_cpu_busy <= 1'b0;

            chr_rd <= w_acc && !w_we && w_tgt == TGT_CHR;
            if (w_acc && w_tgt == TGT_CHR)
                chr_addr <= w_addr[12:0];

            if (r_s1_vld && r_s1_cpu && r_s1_we && r_s1_tgt == TGT_PAL)
                r_pal[w_pal_idx] <= r_s1_wdata[5:0];

            fetch_valid <= r_s1_vld && !r_s1_cpu;
            if (r_s1_vld && !r_s1_cpu)
                fetch_data <= w_src;

            cpu_done <= r_s1_vld && r_s1_cpu;
            if (r_s1_vld && r_s1_cpu) begin
                if (r_s1_we) begin
                    cpu_rdata <= '0;
                end else if (r_s1_tgt == TGT_PAL) begin
                    cpu_rdata <= w_pal_rd;
                    r_rd_buf  <= w_nt_rd;
                end else begin
                    cpu_rdata <= r_rd_buf;
                    r_rd_buf  <= w_src;
                end
            end
        end
    end

`ifdef PPU_VRAM_CHR_RAM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            chr_we    <= 1'b0;
            chr_wdata <= '0;
        end else begin
            chr_we <= w_we && w_tgt == TGT_CHR;
            if (w_we && w_tgt == TGT_CHR)
                chr_wdata <= cpu_wdata;
        end
    end
`else
    assign chr_we    = 1'b0;
    assign chr_wdata = '0;
`endif

endmodule

// File: doc/ppu_vram_resp.md
# ppu_vram_resp

PPU video-memory responder: the slave end of the PPU VRAM bus that the background/sprite fetch sequencer drives (NT, AT, pattern-low, pattern-high and garbage-NT fetches).
- Decodes each 14-bit PPU address into CHR (external), nametable RAM (internal 2 KB, cartridge-selected mirroring) or palette RAM (internal 32×6).
- Returns data through a fixed-latency pipeline.
- Also serves the CPU $2007 data port, including the NES delayed read buffer.
- Sits between the PPU render sequencers, the CPU register block and the cartridge CHR interface.

## Interface
Parameters:
- NT_AW, 11, nametable RAM address width (2 KB).

Ports:
- clk  in  1  system clock (25 MHz).
- rst  in  1  reset; synchronous, active-high.
- mirror_v  in  1  1 = vertical mirroring, 0 = horizontal.
- fetch_req  in  1  renderer read request, single-cycle pulse.
- fetch_addr  in  14  renderer PPU address.
- fetch_valid  out  1  renderer read data valid, one-cycle pulse.
- fetch_data  out  8  renderer read data.
- cpu_req  in  1  CPU access request; held high until cpu_done.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  14  CPU PPU address (the v register).
- cpu_wdata  in  8  CPU write data.
- cpu_done  out  1  CPU access complete, one-cycle pulse.
- cpu_rdata  out  8  CPU read data, valid with cpu_done.
- chr_rd  out  1  CHR read strobe; chr_data is sampled 1 cycle later.
- chr_we  out  1  CHR write strobe.
- chr_addr  out  13  CHR address.
- chr_wdata  out  8  CHR write data.
- chr_data  in  8  CHR read data.

## Operation
Address decode, applied identically to renderer and CPU accesses:
- **CHR:** addr[13]=0. chr_addr = addr[12:0].
- **Palette:** addr[13:8]=6'h3F.
  - Index = addr[4:0]; if addr[1:0]=0, index bit 4 is forced to 0 (so $3F10/14/18/1C alias $3F00/04/08/0C).
  - Read data = {2'b00, entry[5:0]}.
- **Nametable:** all other addresses ($2000–$3EFF).
  - mirror_v=1: RAM address {addr[10], addr[9:0]}.
  - mirror_v=0: RAM address {addr[11], addr[9:0]}.

Arbitration:
- fetch_req always wins. A cpu_req arriving in the same cycle is accepted on the next cycle with no fetch_req.
- A CPU access is accepted when cpu_req=1, fetch_req=0 and no CPU access is in flight (cpu_busy=0).
- cpu_busy is high from the acceptance cycle through the cpu_done cycle.
- cpu_req still high in the cycle after cpu_done starts a new access.

Pipeline (two stages, one new access per cycle, each stage tagged fetch/cpu):
- **S1:** decode, drive the nametable RAM read/write, drive chr_rd/chr_we, perform palette write.
- **S2:** select the data source, update the read buffer, pulse fetch_valid or cpu_done.

CPU reads:
- Target ≠ palette: cpu_rdata = old rd_buf; rd_buf ← fetched byte.
- Target = palette: cpu_rdata = palette byte; rd_buf ← nametable byte at cpu_addr & 14'h2FFF.

CPU writes:
- Nametable and palette: written in S1.
- CHR: see Configuration.
- cpu_rdata = 0 on write completion.

Renderer reads never modify rd_buf.

## Timing
- Access accepted in cycle N → fetch_valid or cpu_done high in cycle N+2 for exactly one cycle. Applies to reads and writes alike.
- chr_rd, chr_we and chr_addr are registered outputs, asserted in cycle N+1.
- fetch_data and cpu_rdata hold their value until the next completion of the same tag.
- Back-to-back fetch_req on consecutive cycles is supported, with back-to-back fetch_valid.
- Reset values:
  - fetch_valid, cpu_done, chr_rd, chr_we = 0.
  - fetch_data, cpu_rdata, chr_addr, chr_wdata = 0.
  - rd_buf = 0, cpu_busy = 0, palette entries = 0.
  - Nametable RAM contents are not reset.
- rst asserted mid-access: all in-flight accesses are dropped and no valid/done pulse is issued for them. cpu_req must be re-presented after reset.
- mirror_v is sampled at S1. Changing it between accesses is legal.

## Configuration
- **PPU_VRAM_CHR_RAM_EN defined:** a CPU write to $0000–$1FFF pulses chr_we at N+1 with chr_addr and chr_wdata (cartridge CHR-RAM).
- **Not defined:** CHR writes are dropped. chr_we is tied to 0 and chr_wdata to 0. cpu_done still pulses at N+2.
- Renderer access never writes in either case.

## Test plan
- Reset, mirror_v=1: CPU write 8'hA5 to $2005, then renderer fetch $2805 → fetch_valid at N+2 with fetch_data=8'hA5. With mirror_v=0, a renderer fetch of $2405 returns 8'hA5.
- CPU write 8'h2A to $3F10, then renderer fetch $3F00 → 8'h2A. CPU write 8'hFF to $3F01, then read $3F01 → cpu_rdata=8'h3F.
- Buffered read: $2005=8'h11, $2006=8'h22. CPU read $2005 → cpu_rdata=8'h00 (reset buffer). CPU read $2006 → 8'h11. A following palette read of $3F01 loads rd_buf from $2F01.
- fetch_req and cpu_req in the same cycle N → fetch_valid at N+2, cpu_done at N+3. Consecutive fetches at N and N+1 → fetch_valid at N+2 and N+3.
- Renderer fetch $1234 → chr_rd=1 with chr_addr=13'h1234 at N+1. Model returns 8'h5C → fetch_data=8'h5C at N+2.
- CPU write 8'h77 to $0100:
  - With PPU_VRAM_CHR_RAM_EN: chr_we=1 with chr_wdata=8'h77 at N+1.
  - Without it: chr_we stays 0 and cpu_done is still at N+2.
  - Reset asserted at N+1 of any access → no done/valid pulse follows.
